// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: walks W-bit operands C bits per clock, MSB chunk
// first, stopping at the first differing chunk; signed mode is folded into unsigned.
module seq_mag_cmp #(
  parameter int W = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int N  = W / C;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           eq_q, eq_d;
  logic           gt_q, gt_d;
  logic           lt_q, lt_d;

  logic [C-1:0]   a_chunks [N];
  logic [C-1:0]   b_chunks [N];
  logic [C-1:0]   ca, cb;

  // Chunk i covers bits [W-1-i*C -: C]; index 0 is the most significant chunk.
  for (genvar i = 0; i < N; i++) begin : g_chunk
    assign a_chunks[i] = a_q[W-1-i*C -: C];
    assign b_chunks[i] = b_q[W-1-i*C -: C];
  end

  if (N == 1) begin : g_sel_one
    assign ca = a_chunks[0];
    assign cb = b_chunks[0];
  end else begin : g_sel_many
    assign ca = a_chunks[k_q];
    assign cb = b_chunks[k_q];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping the MSB of both operands maps two's complement onto offset
          // binary, so the chunk walk below is always an unsigned compare.
          a_d         = a;
          a_d[W-1]    = a[W-1] ^ sgn;
          b_d         = b;
          b_d[W-1]    = b[W-1] ^ sgn;
          k_d         = '0;
          state_d     = OP;
        end
      end
      OP: begin
        if (ca != cb) begin
          eq_d    = 1'b0;
          gt_d    = (ca > cb);
          lt_d    = (ca < cb);
          state_d = DONE;
        end else if (k_q == K_LAST) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // All outputs come straight from state or result flops.
  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Randomized and directed bench for seq_mag_cmp at (16,4), (8,8) and (12,3), checked
// each cycle against a latency/result model derived from plain integer compares.
module tb_seq_mag_cmp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_i  [3];
  logic [15:0] b_i  [3];
  logic        st_i [3];
  logic        sg_i [3];
  logic        rdy  [3];
  logic        dn   [3];
  logic        eqo  [3];
  logic        gto  [3];
  logic        lto  [3];

  int WV [3] = '{16, 8, 12};
  int CV [3] = '{4, 8, 3};

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  seq_mag_cmp #(.W(16), .C(4)) u_d0 (
    .clk(clk), .reset_n(rst_n), .start(st_i[0]), .sgn(sg_i[0]),
    .a(a_i[0]), .b(b_i[0]), .ready(rdy[0]), .done_tick(dn[0]),
    .eq(eqo[0]), .gt(gto[0]), .lt(lto[0]));

  seq_mag_cmp #(.W(8), .C(8)) u_d1 (
    .clk(clk), .reset_n(rst_n), .start(st_i[1]), .sgn(sg_i[1]),
    .a(a_i[1][7:0]), .b(b_i[1][7:0]), .ready(rdy[1]), .done_tick(dn[1]),
    .eq(eqo[1]), .gt(gto[1]), .lt(lto[1]));

  seq_mag_cmp #(.W(12), .C(3)) u_d2 (
    .clk(clk), .reset_n(rst_n), .start(st_i[2]), .sgn(sg_i[2]),
    .a(a_i[2][11:0]), .b(b_i[2][11:0]), .ready(rdy[2]), .done_tick(dn[2]),
    .eq(eqo[2]), .gt(gto[2]), .lt(lto[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns (result << 8) | j, result 0=eq 1=gt 2=lt, j = first differing chunk.
  function automatic int ref_enc(input int id, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    int w, c, n, j, res;
    longint av, bv, msk, cmsk, ca, cb;
    w    = WV[id];
    c    = CV[id];
    n    = w / c;
    msk  = (longint'(1) << w) - 1;
    cmsk = (longint'(1) << c) - 1;
    av   = longint'(a) & msk;
    bv   = longint'(b) & msk;
    if (s) begin
      if (av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    end
    res = (av == bv) ? 0 : ((av > bv) ? 1 : 2);
    j = n - 1;
    for (int i = 0; i < n; i++) begin
      ca = (longint'(a) >> (w - (i + 1) * c)) & cmsk;
      cb = (longint'(b) >> (w - (i + 1) * c)) & cmsk;
      if (ca != cb) begin
        j = i;
        break;
      end
    end
    return (res << 8) | j;
  endfunction

  // Cycle model: -1 = idle; otherwise edges since the accepting edge.
  int   m_phase [3];
  int   m_enc   [3];
  logic m_rdy   [3];
  logic m_dn    [3];
  logic m_eq    [3];
  logic m_gt    [3];
  logic m_lt    [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int id = 0; id < 3; id++) begin
        m_phase[id] <= -1;
        m_enc[id]   <= 0;
        m_rdy[id]   <= 1'b1;
        m_dn[id]    <= 1'b0;
        m_eq[id]    <= 1'b0;
        m_gt[id]    <= 1'b0;
        m_lt[id]    <= 1'b0;
      end
    end else begin
      for (int id = 0; id < 3; id++) begin
        if (m_phase[id] < 0) begin
          if (st_i[id]) begin
            m_enc[id]   <= ref_enc(id, a_i[id], b_i[id], sg_i[id]);
            m_phase[id] <= 0;
            m_rdy[id]   <= 1'b0;
          end
        end else begin
          m_phase[id] <= m_phase[id] + 1;
          m_dn[id]    <= 1'b0;
          if (m_phase[id] == (m_enc[id] & 255)) begin
            m_dn[id] <= 1'b1;
            m_eq[id] <= ((m_enc[id] >> 8) == 0);
            m_gt[id] <= ((m_enc[id] >> 8) == 1);
            m_lt[id] <= ((m_enc[id] >> 8) == 2);
          end else if (m_phase[id] == (m_enc[id] & 255) + 1) begin
            m_phase[id] <= -1;
            m_rdy[id]   <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int id = 0; id < 3; id++) begin
        check($sformatf("d%0d_ready", id), int'(rdy[id]), int'(m_rdy[id]));
        check($sformatf("d%0d_done", id),  int'(dn[id]),  int'(m_dn[id]));
        check($sformatf("d%0d_eq", id),    int'(eqo[id]), int'(m_eq[id]));
        check($sformatf("d%0d_gt", id),    int'(gto[id]), int'(m_gt[id]));
        check($sformatf("d%0d_lt", id),    int'(lto[id]), int'(m_lt[id]));
      end
    end
  end

  function automatic int dut_res(input int id);
    if (eqo[id]) return 0;
    if (gto[id]) return 1;
    if (lto[id]) return 2;
    return 3;
  endfunction

  // Called one step after a rising edge with the DUT idle; returns latency in edges
  // from start assertion to done_tick, and the reported result. Ends back in idle.
  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic s, output int lat, output int res);
    int held;
    held     = dut_res(id);
    a_i[id]  = a;
    b_i[id]  = b;
    sg_i[id] = s;
    st_i[id] = 1'b1;
    lat      = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        st_i[id] = 1'b0;
        a_i[id]  = 16'($urandom);
        b_i[id]  = 16'($urandom);
        sg_i[id] = 1'($urandom);
      end
      if (dn[id]) break;
      check($sformatf("d%0d_held", id), dut_res(id), held);
    end
    if (!dn[id]) check($sformatf("d%0d_done_timeout", id), 0, 1);
    res = dut_res(id);
    @(posedge clk);
    #1;
  endtask

  int lat, res, enc, w, c, n, kk;
  logic [15:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    for (int id = 0; id < 3; id++) begin
      a_i[id] = '0; b_i[id] = '0; st_i[id] = 1'b0; sg_i[id] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(rdy[0]), 1);
    check("rst_done",  int'(dn[0]), 0);
    check("rst_eq",    int'(eqo[0]), 0);
    check("rst_gt",    int'(gto[0]), 0);
    check("rst_lt",    int'(lto[0]), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed pins for the reference model itself.
    check("ref_u_8000_7fff", ref_enc(0, 16'h8000, 16'h7FFF, 1'b0), (1 << 8) | 0);
    check("ref_s_8000_7fff", ref_enc(0, 16'h8000, 16'h7FFF, 1'b1), (2 << 8) | 0);
    check("ref_eq_1234",     ref_enc(0, 16'h1234, 16'h1234, 1'b0), (0 << 8) | 3);
    check("ref_w12_s",       ref_enc(2, 16'h0800, 16'h07FF, 1'b1), (2 << 8) | 0);
    check("ref_w8_u",        ref_enc(1, 16'h0080, 16'h007F, 1'b0), (1 << 8) | 0);

    run_op(0, 16'h1234, 16'h1234, 1'b0, lat, res);
    check("eq1234_lat", lat, 5);
    check("eq1234_res", res, 0);

    run_op(0, 16'h8000, 16'h7FFF, 1'b0, lat, res);
    check("u8000_lat", lat, 2);
    check("u8000_res", res, 1);
    run_op(0, 16'h8000, 16'h7FFF, 1'b1, lat, res);
    check("s8000_lat", lat, 2);
    check("s8000_res", res, 2);

    run_op(0, 16'hFFFF, 16'hFFFE, 1'b1, lat, res);
    check("sFFFF_lat", lat, 5);
    check("sFFFF_res", res, 1);
    run_op(0, 16'h0001, 16'h0002, 1'b0, lat, res);
    check("u0001_lat", lat, 5);
    check("u0001_res", res, 2);

    // Starts during OP and DONE must be ignored.
    a_i[0] = 16'h00F0; b_i[0] = 16'h00F1; sg_i[0] = 1'b0; st_i[0] = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk);
      #1;
      st_i[0] = 1'b0;
      if (cyc == 2 || cyc == 5) begin
        st_i[0] = 1'b1; a_i[0] = '0; b_i[0] = '0;
      end
      if (cyc < 5) check("ign_no_early_done", int'(dn[0]), 0);
      check("ign_ready_low", int'(rdy[0]), 0);
    end
    check("ign_done", int'(dn[0]), 1);
    check("ign_lt", int'(lto[0]), 1);
    @(posedge clk);
    #1;
    st_i[0] = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      check("ign_ready_back", int'(rdy[0]), 1);
      check("ign_no_extra_done", int'(dn[0]), 0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a compare.
    a_i[0] = 16'h1234; b_i[0] = 16'h1234; st_i[0] = 1'b1;
    @(posedge clk);
    #1;
    st_i[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(rdy[0]), 1);
    check("mid_rst_done",  int'(dn[0]), 0);
    check("mid_rst_eq",    int'(eqo[0]), 0);
    check("mid_rst_gt",    int'(gto[0]), 0);
    check("mid_rst_lt",    int'(lto[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_done", int'(dn[0]), 0);
    end
    run_op(0, 16'hA5A5, 16'hA5A5, 1'b0, lat, res);
    check("a5a5_lat", lat, 5);
    check("a5a5_res", res, 0);

    // Randomized sweep over all three geometries.
    for (int id = 0; id < 3; id++) begin
      w = WV[id];
      c = CV[id];
      n = w / c;
      for (int it = 0; it < 1000; it++) begin
        ra = 16'($urandom);
        case ($urandom_range(0, 2))
          0: rb = 16'($urandom);
          1: rb = ra;
          default: begin
            kk = $urandom_range(0, n - 1);
            rb = ra ^ 16'($urandom_range(1, (1 << c) - 1) << (c * kk));
          end
        endcase
        enc = ref_enc(id, ra, rb, 1'($urandom));
        run_op(id, ra, rb, 1'(m_enc[id] == m_enc[id] ? 0 : 1), lat, res);
        enc = m_enc[id];
        check($sformatf("sw%0d_res", id), res, enc >> 8);
        check($sformatf("sw%0d_lat", id), lat, (enc & 255) + 2);
      end
      for (int it = 0; it < 1000; it++) begin
        ra = 16'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
        run_op(id, ra, rb, 1'b1, lat, res);
        enc = ref_enc(id, ra, rb, 1'b1);
        check($sformatf("sw%0d_sres", id), res, enc >> 8);
        check($sformatf("sw%0d_slat", id), lat, (enc & 255) + 2);
      end
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
